// File: rtl/fifo_pkt_reader_pkg.sv
// Shared definitions for the FIFO packet reader.
//   state_t : framing state (header fetch / payload fetch)
//   LEN_LSB : bit position of the length field inside a header word
//   tag_t   : description of the FIFO word returning the cycle after an ack
package fifo_pkt_reader_pkg;

  typedef enum logic {
    S_HDR = 1'b0,
    S_PAY = 1'b1
  } state_t;

  localparam int LEN_LSB = 0;

  typedef struct packed {
    logic v;    // a word is returning next cycle
    logic hdr;  // that word is a header
    logic sop;  // first payload word of the packet
    logic eop;  // last payload word of the packet
  } tag_t;

endpackage

// File: rtl/fifo_pkt_reader_obuf.sv
// 4-entry output buffer holding {data, sop, eop} for the payload stream.
// Ports:
//   rd_clk, rst_n        clock, asynchronous active-low reset
//   clr                  synchronous flush
//   push, push_*         write one entry (returning payload word)
//   pop                  remove head entry (stream handshake)
//   occ                  occupancy 0..4
//   valid, head_*        head entry; zero when empty
module fifo_pkt_reader_obuf #(
  parameter int DATA_WIDTH = 72
) (
  input  logic                  rd_clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  push_sop,
  input  logic                  push_eop,
  input  logic                  pop,
  output logic [2:0]            occ,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic                  head_sop,
  output logic                  head_eop
);

  logic [DATA_WIDTH+1:0] mem_q [4];
  logic [1:0]            wr_ptr_q, wr_ptr_d;
  logic [1:0]            rd_ptr_q, rd_ptr_d;
  logic [2:0]            occ_q, occ_d;
  logic                  do_pop;

  always_comb begin
    do_pop   = pop & (occ_q != 3'd0);
    wr_ptr_d = push   ? wr_ptr_q + 2'd1 : wr_ptr_q;
    rd_ptr_d = do_pop ? rd_ptr_q + 2'd1 : rd_ptr_q;
    occ_d    = occ_q + {2'b0, push} - {2'b0, do_pop};
    if (clr) begin
      wr_ptr_d = 2'd0;
      rd_ptr_d = 2'd0;
      occ_d    = 3'd0;
    end
  end

  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= 2'd0;
      rd_ptr_q <= 2'd0;
      occ_q    <= 3'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  // Storage carries no reset; entries are only observed through occ.
  always_ff @(posedge rd_clk) begin
    if (push) mem_q[wr_ptr_q] <= {push_data, push_sop, push_eop};
  end

  assign occ   = occ_q;
  assign valid = (occ_q != 3'd0);
  // Head is forced to zero when empty so outputs are clean out of reset.
  assign {head_data, head_sop, head_eop} = valid ? mem_q[rd_ptr_q] : '0;

  a_no_overflow: assert property (@(posedge rd_clk) disable iff (!rst_n)
    !(push && occ_q == 3'd4));

endmodule

// File: rtl/fifo_pkt_reader.sv
// Read-side consumer for the dual-clock FIFO (look-ahead disabled: data
// returns one rd_clk after fifo_rd_ack). Drains length-framed packets
// (one header word holding the payload length, then the payload words)
// and emits the payload as a valid/ready stream with sop/eop.
// Ports:
//   rd_clk, rst_n, clr          clock, async active-low reset, sync clear
//   fifo_rd_ack/data/empty      FIFO read port; fifo_rd_level status only
//   m_valid/ready/data/sop/eop  payload stream
//   pkt_count, zero_len_count   wrapping event counters
//   busy                        packet in progress anywhere in the reader
module fifo_pkt_reader
  import fifo_pkt_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 72,
  parameter int ADDR_WIDTH = 7,
  parameter int LEN_WIDTH  = 12,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  rd_clk,
  input  logic                  rst_n,
  input  logic                  clr,
  output logic                  fifo_rd_ack,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  input  logic                  fifo_rd_empty,
  input  logic [ADDR_WIDTH:0]   fifo_rd_level,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_sop,
  output logic                  m_eop,
  output logic [CNT_WIDTH-1:0]  pkt_count,
  output logic [CNT_WIDTH-1:0]  zero_len_count,
  output logic                  busy
);

  state_t               state_q, state_d;
  tag_t                 tag_q, tag_d;
  logic [LEN_WIDTH-1:0] acks_left_q, acks_left_d;
  logic                 first_q, first_d;
  logic [CNT_WIDTH-1:0] pkt_count_q, pkt_count_d;
  logic [CNT_WIDTH-1:0] zero_len_count_q, zero_len_count_d;
  logic                 busy_q, busy_d;

  logic [2:0]           occ, occ_next;
  logic                 push, pop, ack_ok;
  logic [LEN_WIDTH-1:0] hdr_len;
  logic                 unused_level;

  assign unused_level = ^fifo_rd_level;

  assign push    = tag_q.v & ~tag_q.hdr;
  assign pop     = m_valid & m_ready;
  assign hdr_len = fifo_rd_data[LEN_LSB +: LEN_WIDTH];
  assign occ_next = occ + {2'b0, push} - {2'b0, pop};

  // Ack gating uses registered state only; m_ready reaches it solely
  // through the registered occupancy.
  always_comb begin
    if (state_q == S_HDR) ack_ok = ~tag_q.v;
    else ack_ok = ((occ + {2'b0, tag_q.v}) < 3'd4) && (acks_left_q != '0);
    fifo_rd_ack = ack_ok & ~fifo_rd_empty & ~clr;
  end

  always_comb begin
    state_d          = state_q;
    tag_d            = '0;
    acks_left_d      = acks_left_q;
    first_d          = first_q;
    pkt_count_d      = pkt_count_q;
    zero_len_count_d = zero_len_count_q;

    if (pop && m_eop) pkt_count_d = pkt_count_q + CNT_WIDTH'(1);

    // Header arrival: zero-length packets are dropped and counted.
    if (tag_q.v && tag_q.hdr) begin
      if (hdr_len == '0) begin
        zero_len_count_d = zero_len_count_q + CNT_WIDTH'(1);
      end else begin
        acks_left_d = hdr_len;
        first_d     = 1'b1;
        state_d     = S_PAY;
      end
    end

    if (fifo_rd_ack) begin
      tag_d.v = 1'b1;
      if (state_q == S_HDR) begin
        tag_d.hdr = 1'b1;
      end else begin
        tag_d.sop   = first_q;
        tag_d.eop   = (acks_left_q == LEN_WIDTH'(1));
        acks_left_d = acks_left_q - LEN_WIDTH'(1);
        first_d     = 1'b0;
        if (acks_left_q == LEN_WIDTH'(1)) state_d = S_HDR;
      end
    end

    busy_d = (state_d == S_PAY) | tag_d.v | (occ_next != 3'd0);

    // Clear drops the in-flight word and restarts framing.
    if (clr) begin
      state_d          = S_HDR;
      tag_d            = '0;
      acks_left_d      = '0;
      first_d          = 1'b0;
      pkt_count_d      = '0;
      zero_len_count_d = '0;
      busy_d           = 1'b0;
    end
  end

  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= S_HDR;
      tag_q            <= '0;
      acks_left_q      <= '0;
      first_q          <= 1'b0;
      pkt_count_q      <= '0;
      zero_len_count_q <= '0;
      busy_q           <= 1'b0;
    end else begin
      state_q          <= state_d;
      tag_q            <= tag_d;
      acks_left_q      <= acks_left_d;
      first_q          <= first_d;
      pkt_count_q      <= pkt_count_d;
      zero_len_count_q <= zero_len_count_d;
      busy_q           <= busy_d;
    end
  end

  fifo_pkt_reader_obuf #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_obuf (
    .rd_clk    (rd_clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .push      (push),
    .push_data (fifo_rd_data),
    .push_sop  (tag_q.sop),
    .push_eop  (tag_q.eop),
    .pop       (pop),
    .occ       (occ),
    .valid     (m_valid),
    .head_data (m_data),
    .head_sop  (m_sop),
    .head_eop  (m_eop)
  );

  assign pkt_count      = pkt_count_q;
  assign zero_len_count = zero_len_count_q;
  assign busy           = busy_q;

  a_no_ack_empty: assert property (@(posedge rd_clk) disable iff (!rst_n)
    !(fifo_rd_ack && fifo_rd_empty));

endmodule

// File: tb/tb_fifo_pkt_reader.sv
module tb_fifo_pkt_reader;
  localparam int DW = 72;
  localparam int AW = 7;
  localparam int LW = 12;
  localparam int CW = 16;

  typedef logic [DW+1:0] cv_t;

  logic          rd_clk = 1'b0;
  logic          rst_n;
  logic          clr;
  logic          fifo_rd_ack;
  logic [DW-1:0] fifo_rd_data;
  logic          fifo_rd_empty;
  logic [AW:0]   fifo_rd_level;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          m_sop;
  logic          m_eop;
  logic [CW-1:0] pkt_count;
  logic [CW-1:0] zero_len_count;
  logic          busy;

  always #5 rd_clk = ~rd_clk;

  fifo_pkt_reader #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .CNT_WIDTH(CW)
  ) dut (
    .rd_clk         (rd_clk),
    .rst_n          (rst_n),
    .clr            (clr),
    .fifo_rd_ack    (fifo_rd_ack),
    .fifo_rd_data   (fifo_rd_data),
    .fifo_rd_empty  (fifo_rd_empty),
    .fifo_rd_level  (fifo_rd_level),
    .m_valid        (m_valid),
    .m_ready        (m_ready),
    .m_data         (m_data),
    .m_sop          (m_sop),
    .m_eop          (m_eop),
    .pkt_count      (pkt_count),
    .zero_len_count (zero_len_count),
    .busy           (busy)
  );

  // Reference model: upstream FIFO contents, expected stream beats.
  logic [DW-1:0] fq[$];
  bit            hq[$];
  cv_t           exp_q[$];
  int            exp_pkt, exp_zl;
  int            held, pay_acks, cyc_n;
  int            ack_cyc[$];
  int            beat_cyc[$];
  bit            ack_prev;
  logic [DW-1:0] data_prev;
  bit            stall, ready_drv, clr_drv, rand_mode;

  int total = 0;
  int bad   = 0;

  task automatic check_val(input string tag, input cv_t got, input cv_t want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, want);
    end
  endtask

  // One rd_clk cycle: drive at negedge, observe 1 time unit later.
  task automatic cyc();
    cv_t e;
    @(negedge rd_clk);
    cyc_n++;
    if (ack_prev) fifo_rd_data = data_prev;
    ack_prev = 1'b0;
    if (rand_mode) begin
      ready_drv = ($urandom_range(0, 9) < 7);
      stall     = ($urandom_range(0, 9) < 2);
    end
    m_ready       = ready_drv;
    clr           = clr_drv;
    fifo_rd_empty = (fq.size() == 0) || stall;
    fifo_rd_level = (fq.size() > 128) ? 8'd128 : 8'(fq.size());
    #1;
    if (fifo_rd_ack && fifo_rd_empty) check_val("ack_on_empty", cv_t'(1), cv_t'(0));
    if (fifo_rd_ack && fq.size() != 0) begin
      data_prev = fq.pop_front();
      ack_prev  = 1'b1;
      ack_cyc.push_back(cyc_n);
      if (!hq.pop_front()) begin
        pay_acks++;
        held++;
      end
    end
    if (!clr_drv && m_valid && m_ready) begin
      beat_cyc.push_back(cyc_n);
      if (exp_q.size() == 0) begin
        check_val("extra_beat", cv_t'(1), cv_t'(0));
      end else begin
        e = exp_q.pop_front();
        check_val("beat", {m_data, m_sop, m_eop}, e);
        if (e[0]) exp_pkt++;
      end
      held--;
    end
    if (held > 4) check_val("held_max", cv_t'(held), cv_t'(4));
  endtask

  task automatic push_pkt(input int len);
    logic [DW-1:0] w;
    w = {8'($urandom), $urandom, $urandom};
    w[LW-1:0] = LW'(len);
    fq.push_back(w);
    hq.push_back(1'b1);
    if (len == 0) exp_zl++;
    for (int i = 0; i < len; i++) begin
      w = {8'($urandom), $urandom, $urandom};
      fq.push_back(w);
      hq.push_back(1'b0);
      exp_q.push_back({w, (i == 0), (i == len - 1)});
    end
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((fq.size() != 0 || exp_q.size() != 0 || ack_prev || m_valid || busy)
           && n < 20000) begin
      cyc();
      n++;
    end
    if (n >= 20000) check_val({tag, "_timeout"}, cv_t'(1), cv_t'(0));
    repeat (2) cyc();
  endtask

  task automatic do_clr();
    clr_drv = 1'b1;
    cyc();
    clr_drv = 1'b0;
    fq.delete();
    hq.delete();
    exp_q.delete();
    held     = 0;
    ack_prev = 1'b0;
    exp_pkt  = 0;
    exp_zl   = 0;
  endtask

  initial begin
    int base, n;
    rst_n = 1'b0; clr = 1'b0; fifo_rd_empty = 1'b1; fifo_rd_data = '0;
    fifo_rd_level = '0; m_ready = 1'b0;
    ready_drv = 1'b0; stall = 1'b0; clr_drv = 1'b0; rand_mode = 1'b0;
    ack_prev = 1'b0; data_prev = '0;
    exp_pkt = 0; exp_zl = 0; held = 0; pay_acks = 0; cyc_n = 0;

    repeat (3) @(negedge rd_clk);
    #1;
    check_val("rst_valid", cv_t'(m_valid), cv_t'(0));
    check_val("rst_out", {m_data, m_sop, m_eop}, cv_t'(0));
    check_val("rst_busy", cv_t'(busy), cv_t'(0));
    check_val("rst_cnts", cv_t'({pkt_count, zero_len_count}), cv_t'(0));
    check_val("rst_ack", cv_t'(fifo_rd_ack), cv_t'(0));
    rst_n = 1'b1;

    // len=3, sink always ready
    ready_drv = 1'b1;
    ack_cyc.delete(); beat_cyc.delete();
    push_pkt(3);
    drain("s1");
    check_val("s1_pkt", cv_t'(pkt_count), cv_t'(1));
    check_val("s1_busy", cv_t'(busy), cv_t'(0));
    check_val("s1_beats", cv_t'(beat_cyc.size()), cv_t'(3));
    if (beat_cyc.size() == 3 && ack_cyc.size() >= 2) begin
      check_val("s1_back2back", cv_t'(beat_cyc[2] - beat_cyc[0]), cv_t'(2));
      check_val("s1_latency", cv_t'(beat_cyc[0] - ack_cyc[1]), cv_t'(2));
    end

    // zero-length header followed by len=1
    push_pkt(0);
    push_pkt(1);
    drain("s2");
    check_val("s2_zl", cv_t'(zero_len_count), cv_t'(1));
    check_val("s2_pkt", cv_t'(pkt_count), cv_t'(2));

    // len=8 against a stalled sink
    ready_drv = 1'b0;
    pay_acks  = 0;
    push_pkt(8);
    repeat (10) cyc();
    check_val("s3_acks_stalled", cv_t'(pay_acks), cv_t'(4));
    check_val("s3_valid", cv_t'(m_valid), cv_t'(1));
    ready_drv = 1'b1;
    drain("s3");
    check_val("s3_pkt", cv_t'(pkt_count), cv_t'(3));

    // len=5 with the FIFO going empty after the 2nd payload word
    pay_acks = 0;
    push_pkt(5);
    n = 0;
    while (pay_acks < 2 && n < 50) begin cyc(); n++; end
    check_val("s4_reach", cv_t'(pay_acks), cv_t'(2));
    stall = 1'b1;
    base  = pay_acks;
    repeat (3) cyc();
    check_val("s4_stall_acks", cv_t'(pay_acks), cv_t'(base));
    stall = 1'b0;
    drain("s4");
    check_val("s4_pkt", cv_t'(pkt_count), cv_t'(4));

    // two back-to-back len=2 packets
    ack_cyc.delete(); beat_cyc.delete();
    push_pkt(2);
    push_pkt(2);
    drain("s5");
    check_val("s5_acks", cv_t'(ack_cyc.size()), cv_t'(6));
    if (ack_cyc.size() == 6)
      check_val("s5_hdr_gap", cv_t'(ack_cyc[3] - ack_cyc[2]), cv_t'(2));
    check_val("s5_pkt", cv_t'(pkt_count), cv_t'(6));

    // clear mid-packet with words buffered
    ready_drv = 1'b0;
    push_pkt(6);
    n = 0;
    while (held < 2 && n < 50) begin cyc(); n++; end
    check_val("s6_held", cv_t'(held), cv_t'(2));
    do_clr();
    cyc();
    check_val("s6_valid", cv_t'(m_valid), cv_t'(0));
    check_val("s6_busy", cv_t'(busy), cv_t'(0));
    check_val("s6_cnts", cv_t'({pkt_count, zero_len_count}), cv_t'(0));
    ready_drv = 1'b1;
    push_pkt(1);
    drain("s6");
    check_val("s6_pkt", cv_t'(pkt_count), cv_t'(1));

    // randomized traffic including the maximum length
    do_clr();
    rand_mode = 1'b1;
    for (int p = 0; p < 30; p++) begin
      push_pkt($urandom_range(0, 9));
      if (p == 15) push_pkt((1 << LW) - 1);
    end
    drain("s7");
    rand_mode = 1'b0;
    ready_drv = 1'b1;
    stall     = 1'b0;
    check_val("s7_leftover", cv_t'(exp_q.size()), cv_t'(0));
    check_val("s7_pkt", cv_t'(pkt_count), cv_t'(CW'(exp_pkt)));
    check_val("s7_zl", cv_t'(zero_len_count), cv_t'(CW'(exp_zl)));
    check_val("s7_busy", cv_t'(busy), cv_t'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got=running want=finished");
    $fatal(1, "watchdog");
  end

endmodule
